z_result_stage: RTL and testbench

Z_RESULT_STAGE -- requirements
Module: z_result_stage

---
 rtl/z_result_stage.sv | 119 +++++++++++
 tb/tb_z_result_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/z_result_stage.sv
// Two-entry in-order result buffer between ALU and the Z datapath bus.
// Optional per-entry zero/negative flags are built when Z_FLAGS_EN is defined.
module z_result_stage (
  input  logic        clock,
  input  logic        clear,
  input  logic        alu_valid,
  input  logic [31:0] alu_rz_lo,
  input  logic [31:0] alu_rz_hi,
  output logic        alu_ready,
  input  logic        z_pop,
  input  logic        Zlowout,
  input  logic        Zhighout,
  output logic        z_valid,
  output logic [31:0] bus_z,
  output logic [1:0]  count,
  output logic        sel_err,
  output logic        flag_zero,
  output logic        flag_neg
);

  logic [63:0] mem_q [2];
  logic [63:0] mem_d [2];
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        sel_err_q, sel_err_d;
  logic        push, pop;
  logic [63:0] head;

  // ready depends only on registered occupancy, never on z_pop
  assign alu_ready = (count_q != 2'd2);
  assign z_valid   = (count_q != 2'd0);
  assign count     = count_q;
  assign sel_err   = sel_err_q;
  assign push      = alu_valid && alu_ready;
  assign pop       = z_pop && z_valid;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    mem_d     = mem_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    sel_err_d = sel_err_q | (Zlowout & Zhighout);
    if (push) begin
      mem_d[wr_ptr_q] = {alu_rz_hi, alu_rz_lo};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    bus_z = 32'd0;
    if (z_valid) begin
      if (Zlowout) begin
        bus_z = head[31:0];
      end else if (Zhighout) begin
        bus_z = head[63:32];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      sel_err_q <= sel_err_d;
    end
  end

  // payload needs no reset: it is unobservable while count is 0
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

`ifdef Z_FLAGS_EN
  logic [1:0] zf_q, zf_d;
  logic [1:0] nf_q, nf_d;

  always_comb begin
    zf_d = zf_q;
    nf_d = nf_q;
    if (push) begin
      zf_d[wr_ptr_q] = ({alu_rz_hi, alu_rz_lo} == 64'd0);
      nf_d[wr_ptr_q] = alu_rz_hi[31];
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      zf_q <= 2'b00;
      nf_q <= 2'b00;
    end else begin
      zf_q <= zf_d;
      nf_q <= nf_d;
    end
  end

  assign flag_zero = z_valid & zf_q[rd_ptr_q];
  assign flag_neg  = z_valid & nf_q[rd_ptr_q];
`else
  assign flag_zero = 1'b0;
  assign flag_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_z_result_stage.sv
// Directed test of the two-entry Z result buffer.
// Flag expectations follow whether Z_FLAGS_EN is defined.
module tb_z_result_stage;

  logic        clock = 1'b0;
  logic        clear;
  logic        alu_valid;
  logic [31:0] alu_rz_lo;
  logic [31:0] alu_rz_hi;
  logic        alu_ready;
  logic        z_pop;
  logic        Zlowout;
  logic        Zhighout;
  logic        z_valid;
  logic [31:0] bus_z;
  logic [1:0]  count;
  logic        sel_err;
  logic        flag_zero;
  logic        flag_neg;

  int total = 0;
  int bad   = 0;

`ifdef Z_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  z_result_stage dut (
    .clock     (clock),
    .clear     (clear),
    .alu_valid (alu_valid),
    .alu_rz_lo (alu_rz_lo),
    .alu_rz_hi (alu_rz_hi),
    .alu_ready (alu_ready),
    .z_pop     (z_pop),
    .Zlowout   (Zlowout),
    .Zhighout  (Zhighout),
    .z_valid   (z_valid),
    .bus_z     (bus_z),
    .count     (count),
    .sel_err   (sel_err),
    .flag_zero (flag_zero),
    .flag_neg  (flag_neg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] hi, input logic [31:0] lo);
    alu_valid = 1'b1;
    alu_rz_hi = hi;
    alu_rz_lo = lo;
    tick();
    alu_valid = 1'b0;
  endtask

  task automatic pop();
    z_pop = 1'b1;
    tick();
    z_pop = 1'b0;
  endtask

  task automatic sel(input logic lo, input logic hi);
    Zlowout  = lo;
    Zhighout = hi;
    #1;
  endtask

  initial begin
    clear = 1'b1; alu_valid = 1'b0; alu_rz_lo = '0; alu_rz_hi = '0;
    z_pop = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
    tick();
    tick();
    clear = 1'b0;
    sel(1'b1, 1'b0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(z_valid), 64'd0);
    chk("rst_ready", 64'(alu_ready), 64'd1);
    chk("rst_selerr", 64'(sel_err), 64'd0);
    chk("rst_bus", 64'(bus_z), 64'd0);
    chk("rst_flags", 64'({flag_zero, flag_neg}), 64'd0);

    sel(1'b0, 1'b0);
    push(32'h0, 32'h3);
    sel(1'b1, 1'b0);
    chk("p1_valid", 64'(z_valid), 64'd1);
    chk("p1_count", 64'(count), 64'd1);
    chk("p1_bus", 64'(bus_z), 64'h3);
    sel(1'b0, 1'b1);
    chk("p1_bus_hi", 64'(bus_z), 64'h0);
    sel(1'b0, 1'b0);
    chk("p1_bus_none", 64'(bus_z), 64'h0);
    pop();
    chk("p1_pop_count", 64'(count), 64'd0);

    // pointers now at 1: the second push wraps to index 0
    push(32'h0, 32'h11);
    push(32'h0, 32'h22);
    chk("full_ready", 64'(alu_ready), 64'd0);
    chk("full_count", 64'(count), 64'd2);
    push(32'h0, 32'h33);
    chk("drop_count", 64'(count), 64'd2);
    sel(1'b1, 1'b0);
    chk("fifo_h0", 64'(bus_z), 64'h11);
    pop();
    chk("fifo_h1", 64'(bus_z), 64'h22);
    chk("fifo_c1", 64'(count), 64'd1);
    chk("fifo_rdy", 64'(alu_ready), 64'd1);
    pop();
    chk("fifo_c0", 64'(count), 64'd0);
    chk("fifo_bus0", 64'(bus_z), 64'h0);

    push(32'h0, 32'hAA);
    chk("one_head", 64'(bus_z), 64'hAA);
    z_pop = 1'b1;
    push(32'h0, 32'hBB);
    z_pop = 1'b0;
    chk("pp_count", 64'(count), 64'd1);
    chk("pp_bus", 64'(bus_z), 64'hBB);
    pop();
    chk("pp_empty", 64'(count), 64'd0);

    pop();
    chk("epop_count", 64'(count), 64'd0);
    chk("epop_ready", 64'(alu_ready), 64'd1);

    push(32'h0, 32'h1);
    push(32'h0, 32'h2);
    z_pop = 1'b1;
    push(32'h0, 32'h3);
    z_pop = 1'b0;
    chk("fpp_count", 64'(count), 64'd1);
    chk("fpp_bus", 64'(bus_z), 64'h2);
    pop();
    chk("fpp_drop", 64'(z_valid), 64'd0);

    push(32'h8000_0000, 32'h0);
    chk("neg_flag", 64'(flag_neg), 64'(FL));
    chk("neg_zero", 64'(flag_zero), 64'd0);
    sel(1'b0, 1'b1);
    chk("neg_bus_hi", 64'(bus_z), 64'h8000_0000);
    push(32'h0, 32'h0);
    pop();
    chk("zero_flag", 64'(flag_zero), 64'(FL));
    chk("zero_neg", 64'(flag_neg), 64'd0);
    pop();
    chk("flags_empty", 64'({flag_zero, flag_neg}), 64'd0);

    sel(1'b0, 1'b0);
    push(32'h5, 32'h9);
    sel(1'b1, 1'b1);
    chk("both_bus", 64'(bus_z), 64'h9);
    chk("both_pre", 64'(sel_err), 64'd0);
    tick();
    chk("selerr_set", 64'(sel_err), 64'd1);
    sel(1'b0, 1'b1);
    chk("hi_bus", 64'(bus_z), 64'h5);
    tick();
    chk("selerr_hold", 64'(sel_err), 64'd1);

    push(32'h0, 32'h7);
    chk("pre_clr_cnt", 64'(count), 64'd2);
    clear = 1'b1;
    z_pop = 1'b1;
    push(32'h0, 32'h44);
    clear = 1'b0;
    z_pop = 1'b0;
    sel(1'b1, 1'b0);
    chk("clr_count", 64'(count), 64'd0);
    chk("clr_valid", 64'(z_valid), 64'd0);
    chk("clr_ready", 64'(alu_ready), 64'd1);
    chk("clr_bus", 64'(bus_z), 64'h0);
    chk("clr_selerr", 64'(sel_err), 64'd0);
    chk("clr_flags", 64'({flag_zero, flag_neg}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
